// File: rtl/hann_window_sequencer_pkg.sv
// Shared constants, FSM state encoding and Hann coefficient function for the
// chirp window sequencer and its window reader.
package hann_window_sequencer_pkg;

    localparam int N_SAMPLES  = 128;
    localparam int ADDR_WIDTH = 7;
    localparam int LAT        = 3;
    localparam int COEF_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // sin^2(pi*idx/n) scaled to full COEF_W range, using the Bhaskara sine
    // approximation so the ROM folds to constants with integer arithmetic only.
    function automatic logic [COEF_W-1:0] hann_coef(input int unsigned idx,
                                                    input int unsigned n);
        longint u;
        longint num;
        longint den;
        u   = longint'(idx) * longint'(n - idx);
        num = 16 * u;
        den = 5 * longint'(n) * longint'(n) - 4 * u;
        return COEF_W'((num * num * 65535) / (den * den));
    endfunction

endpackage

// File: rtl/hann_window_reader.sv
// Hann window ROM reader: free-running address advanced by enable, tvalid/tdata
// follow enable by exactly LAT cycles; no backpressure.
module hann_window_reader
    import hann_window_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              tvalid,
    output logic [COEF_W-1:0] tdata
);

    logic [COEF_W-1:0]     rom [N_SAMPLES];
    logic [ADDR_WIDTH-1:0] addr;
    logic [LAT-1:0]        vld_sr;
    logic [COEF_W-1:0]     dat_sr [LAT];

    for (genvar i = 0; i < N_SAMPLES; i++) begin : g_rom
        assign rom[i] = hann_coef(i, N_SAMPLES);
    end

    // The address wraps naturally at N_SAMPLES, so it stays aligned only if
    // every chirp delivers exactly N_SAMPLES enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            vld_sr <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= enable;
            if (enable) begin
                dat_sr[0] <= rom[addr];
                addr      <= addr + ADDR_WIDTH'(1);
            end
            for (int i = 1; i < LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                dat_sr[i] <= dat_sr[i-1];
            end
        end
    end

    assign tvalid = vld_sr[LAT-1];
    assign tdata  = dat_sr[LAT-1];

endmodule

// File: rtl/hann_window_sequencer.sv
// Frame/chirp sequencer driving the window reader enable: N_SAMPLES enables per
// chirp, LAT drain cycles, configurable gap; all outputs registered, no backpressure.
module hann_window_sequencer
    import hann_window_sequencer_pkg::*;
#(
    parameter int N_SAMPLES  = hann_window_sequencer_pkg::N_SAMPLES,
    parameter int ADDR_WIDTH = hann_window_sequencer_pkg::ADDR_WIDTH,
    parameter int LAT        = hann_window_sequencer_pkg::LAT,
    parameter int CHIRP_W    = 8,
    parameter int GAP_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CHIRP_W-1:0]    cfg_num_chirps,
    input  logic [GAP_W-1:0]      cfg_gap_cycles,
    output logic                  win_enable,
    output logic [ADDR_WIDTH-1:0] sample_idx,
    output logic [CHIRP_W-1:0]    chirp_idx,
    output logic                  busy,
    output logic                  chirp_done,
    output logic                  frame_done,
    output logic                  aborted
);

    // LAT must be at least 2: chirp_done is raised one drain cycle before
    // the drain phase ends.
    localparam int DRAIN_W = $clog2(LAT) + 1;

    state_t             state;
    logic [CHIRP_W-1:0] num_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               abort_pend;
    logic               last_chirp;
    logic               stop_now;

    assign last_chirp = (chirp_idx + CHIRP_W'(1)) == num_q;
    assign stop_now   = abort_pend | abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            num_q      <= '0;
            gap_q      <= '0;
            gap_cnt    <= '0;
            drain_cnt  <= '0;
            abort_pend <= 1'b0;
            win_enable <= 1'b0;
            sample_idx <= '0;
            chirp_idx  <= '0;
            busy       <= 1'b0;
            chirp_done <= 1'b0;
            frame_done <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            chirp_done <= 1'b0;
            frame_done <= 1'b0;
            aborted    <= 1'b0;
            if (busy && abort) begin
                abort_pend <= 1'b1;
            end

            case (state)
                // A frame ends by returning here with busy still high, so the
                // frame_done cycle is also the last busy cycle.
                ST_IDLE: begin
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start && cfg_num_chirps != '0) begin
                        num_q      <= cfg_num_chirps;
                        gap_q      <= cfg_gap_cycles;
                        chirp_idx  <= '0;
                        abort_pend <= 1'b0;
                        busy       <= 1'b1;
                        win_enable <= 1'b1;
                        sample_idx <= '0;
                        state      <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (sample_idx == ADDR_WIDTH'(N_SAMPLES - 1)) begin
                        win_enable <= 1'b0;
                        drain_cnt  <= '0;
                        state      <= ST_DRAIN;
                    end else begin
                        sample_idx <= sample_idx + ADDR_WIDTH'(1);
                    end
                end

                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_W'(LAT - 2)) begin
                        chirp_done <= 1'b1;
                        drain_cnt  <= drain_cnt + DRAIN_W'(1);
                        if (last_chirp || stop_now) begin
                            frame_done <= 1'b1;
                            aborted    <= stop_now;
                            state      <= ST_IDLE;
                        end
                    end else if (drain_cnt == DRAIN_W'(LAT - 1)) begin
                        chirp_idx <= chirp_idx + CHIRP_W'(1);
                        if (gap_q == '0) begin
                            win_enable <= 1'b1;
                            sample_idx <= '0;
                            state      <= ST_RUN;
                        end else begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end

                ST_GAP: begin
                    if (stop_now) begin
                        frame_done <= 1'b1;
                        aborted    <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (gap_cnt == gap_q - GAP_W'(1)) begin
                        win_enable <= 1'b1;
                        sample_idx <= '0;
                        state      <= ST_RUN;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hann_window_sequencer.sv
// Bench for the sequencer plus window reader: directed scenarios and random frames
// checked cycle by cycle against a chirp-timing model and a real-valued Hann reference.
module tb_hann_window_sequencer;
    import hann_window_sequencer_pkg::*;

    localparam int N   = N_SAMPLES;
    localparam int TOL = 300;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [7:0]        cfg_num_chirps;
    logic [7:0]        cfg_gap_cycles;
    logic              win_enable;
    logic [ADDR_WIDTH-1:0] sample_idx;
    logic [7:0]        chirp_idx;
    logic              busy;
    logic              chirp_done;
    logic              frame_done;
    logic              aborted;
    logic              tvalid;
    logic [COEF_W-1:0] tdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame model: chirp start cycles, chirps actually run, frame_done cycle.
    int m_s [16];
    int m_nch;
    int m_F;
    bit m_ab;

    always #5 clk = ~clk;

    hann_window_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_num_chirps (cfg_num_chirps),
        .cfg_gap_cycles (cfg_gap_cycles),
        .win_enable     (win_enable),
        .sample_idx     (sample_idx),
        .chirp_idx      (chirp_idx),
        .busy           (busy),
        .chirp_done     (chirp_done),
        .frame_done     (frame_done),
        .aborted        (aborted)
    );

    hann_window_reader reader (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (win_enable),
        .tvalid (tvalid),
        .tdata  (tdata)
    );

    // Cycle t is the cycle after edge t-1; start is sampled at edge 0 and an
    // abort driven in cycle a is sampled at edge a.
    task automatic model(input int num, input int gap, input int a);
        int p;
        int s;
        int d;
        p     = N + LAT + gap;
        m_nch = 0;
        m_F   = 0;
        m_ab  = 1'b0;
        for (int k = 0; k < num; k++) begin
            s      = 1 + k * p;
            d      = s + N + LAT - 2;
            m_s[k] = s;
            m_nch  = k + 1;
            if (a >= 1 && a <= d) begin
                m_F = d + 1; m_ab = 1'b1; return;
            end
            if (k == num - 1) begin
                m_F = d + 1; m_ab = 1'b0; return;
            end
            if (gap > 0 && a == d + 1) begin
                m_F = d + 3; m_ab = 1'b1; return;
            end
            if (gap > 0 && a >= d + 2 && a <= d + 1 + gap) begin
                m_F = a + 1; m_ab = 1'b1; return;
            end
        end
    endtask

    function automatic int chirp_of(input int t);
        for (int k = 0; k < m_nch; k++) begin
            if (t >= m_s[k] && t < m_s[k] + N) return k;
        end
        return -1;
    endfunction

    function automatic bit cd_at(input int t);
        for (int k = 0; k < m_nch; k++) begin
            if (t == m_s[k] + N + LAT - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int hann_ref(input int i);
        real r;
        r = $sin(3.14159265358979 * real'(i) / real'(N));
        return $rtoi(65535.0 * r * r + 0.5);
    endfunction

    task automatic check_cycle(input int t);
        int k;
        int kr;
        int diff;
        logic [4:0] exp_v;
        logic [4:0] obs_v;
        k     = chirp_of(t);
        exp_v = {k >= 0, cd_at(t), t == m_F, (t == m_F) && m_ab, t >= 1 && t <= m_F};
        obs_v = {win_enable, chirp_done, frame_done, aborted, busy};
        n_tests++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL ctrl t=%0d en/cd/fd/ab/busy got=%b want=%b", t, obs_v, exp_v);
        end
        if (k >= 0) begin
            n_tests++;
            assert ({sample_idx, chirp_idx} === {ADDR_WIDTH'(t - m_s[k]), 8'(k)}) else begin
                n_fail++;
                $error("FAIL idx t=%0d sample/chirp got=%0d/%0d want=%0d/%0d",
                       t, sample_idx, chirp_idx, t - m_s[k], k);
            end
        end
        kr = chirp_of(t - LAT);
        n_tests++;
        assert (tvalid === (kr >= 0)) else begin
            n_fail++;
            $error("FAIL tvalid t=%0d got=%b want=%b", t, tvalid, kr >= 0);
        end
        if (kr >= 0) begin
            diff = int'(tdata) - hann_ref(t - LAT - m_s[kr]);
            n_tests++;
            assert ((diff <= TOL && diff >= -TOL) === 1'b1) else begin
                n_fail++;
                $error("FAIL tdata t=%0d got=%0d want=%0d+-%0d",
                       t, tdata, hann_ref(t - LAT - m_s[kr]), TOL);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_tests++;
        assert ({win_enable, chirp_done, frame_done, aborted, busy, tvalid, sample_idx, chirp_idx} === '0)
        else begin
            n_fail++;
            $error("FAIL %s got en=%b cd=%b fd=%b ab=%b busy=%b tv=%b si=%0d ci=%0d want all 0",
                   tag, win_enable, chirp_done, frame_done, aborted, busy, tvalid, sample_idx, chirp_idx);
        end
    endtask

    // restart_at / newcfg_at / reset_at: cycle of a mid-frame start, cfg change
    // or asynchronous reset (-1 for none).
    task automatic run_frame(input int num, input int gap, input int a,
                             input int restart_at, input int newcfg_at, input int reset_at);
        model(num, gap, a);
        @(negedge clk);
        cfg_num_chirps = 8'(num);
        cfg_gap_cycles = 8'(gap);
        start = 1'b1;
        abort = 1'b0;
        for (int t = 1; t <= m_F + LAT + 2; t++) begin
            @(negedge clk);
            start = (t == restart_at);
            abort = (t == a);
            if (t == newcfg_at) begin
                cfg_num_chirps = 8'(num + 3);
                cfg_gap_cycles = 8'(gap + 5);
            end
            check_cycle(t);
            if (t == reset_at) begin
                #1 rst_n = 1'b0;
                #1 check_all_zero("async_reset");
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                abort = 1'b0;
                return;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        cfg_num_chirps = '0;
        cfg_gap_cycles = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;

        // Two chirps, gap 4: enables 1-128 and 136-263, frame_done at 266.
        run_frame(2, 4, -1, -1, -1, -1);

        // Zero chirp count: start must be ignored.
        @(negedge clk);
        cfg_num_chirps = '0;
        cfg_gap_cycles = 8'd3;
        start = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            start = 1'b0;
            n_tests++;
            assert ({busy, win_enable} === 2'b00) else begin
                n_fail++;
                $error("FAIL zero_chirps t=%0d busy/en got=%b%b want=00", t, busy, win_enable);
            end
        end

        // Abort mid-RUN with no gap: first chirp completes, frame ends at 131.
        run_frame(4, 0, 50, -1, -1, -1);
        // Abort inside the first gap.
        run_frame(3, 10, 140, -1, -1, -1);
        // Restart during RUN and cfg change mid-frame have no effect.
        run_frame(3, 2, -1, 20, 5, -1);
        // Reset in the middle of RUN, then a clean frame must read from address 0.
        run_frame(2, 3, -1, -1, -1, 60);
        run_frame(1, 0, -1, -1, -1, -1);

        for (int r = 0; r < 6; r++) begin
            int num;
            int gap;
            int a;
            num = $urandom_range(1, 3);
            gap = $urandom_range(0, 12);
            a   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, num * (N + LAT + gap) + 2) : -1;
            run_frame(num, gap, a, ($urandom_range(0, 1) == 1) ? $urandom_range(2, 100) : -1,
                      $urandom_range(1, 120), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hann_window_sequencer.md
HANN_WINDOW_SEQUENCER -- requirements
Module: hann_window_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): N_SAMPLES, 128, Hann window length per chirp; ADDR_WIDTH, 7, log2(N_SAMPLES); LAT, 3, window reader enable-to-tvalid latency in cycles; CHIRP_W, 8, chirp-count width; GAP_W, 8, inter-chirp gap width.
REQ-002 SHALL have ports (name, direction, width, meaning): clk, in, 1, sole clock; rst_n, in, 1, async active-low reset.
REQ-003 SHALL have start, in, 1, frame start pulse.
REQ-004 SHALL have abort, in, 1, stop the frame after the current chirp.
REQ-005 SHALL have cfg_num_chirps, in, CHIRP_W, chirps per frame.
REQ-006 SHALL have cfg_gap_cycles, in, GAP_W, idle cycles between chirps.
REQ-007 SHALL have win_enable, out, 1, drives the window reader enable.
REQ-008 SHALL have sample_idx, out, ADDR_WIDTH, index of the current enable cycle.
REQ-009 SHALL have chirp_idx, out, CHIRP_W, current chirp number.
REQ-010 SHALL have busy, out, 1, frame in progress.
REQ-011 SHALL have chirp_done, out, 1, one-cycle pulse at a chirp's last tvalid.
REQ-012 SHALL have frame_done, out, 1, one-cycle pulse at the end of the frame.
REQ-013 SHALL have aborted, out, 1, qualifies frame_done.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DRAIN, GAP; all outputs registered.
REQ-015 IDLE: start=1 and cfg_num_chirps!=0 -> latch both cfg inputs, clear chirp_idx and abort flag, go RUN; start with cfg_num_chirps=0 is ignored.
REQ-016 start while busy=1 SHALL be ignored; cfg changes mid-frame SHALL have no effect.
REQ-017 RUN: win_enable=1 for exactly N_SAMPLES consecutive cycles; sample_idx counts 0..N_SAMPLES-1, keeping the reader's free-running address aligned to 0 at each chirp start.
REQ-018 With start sampled at edge 0, win_enable SHALL be high in cycles 1..N_SAMPLES.
REQ-019 DRAIN: win_enable=0 for LAT cycles; chirp_done pulses in the last DRAIN cycle (cycle N_SAMPLES+LAT of the chirp).
REQ-020 After DRAIN: if chirp_idx+1 < latched count and no abort pending -> increment chirp_idx, then GAP (or RUN directly if gap=0); otherwise pulse frame_done with the same cycle as chirp_done and go IDLE.
REQ-021 GAP: wait the latched gap-cycle count, then RUN; chirp period P = N_SAMPLES+LAT+gap.
REQ-022 abort SHALL be latched in any busy state. In RUN it SHALL NOT truncate enables: the chirp completes and drains. In GAP it exits to IDLE with frame_done=1 and aborted=1 in the next cycle.
REQ-023 aborted SHALL be 1 only while frame_done=1 and an abort ended the frame.
REQ-024 busy SHALL be 1 from the cycle after accepted start through the frame_done cycle, and 0 the next cycle.
REQ-025 Counters SHALL compare with equality; no wrap beyond the latched limits.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE and set all outputs, counters, latched config and the abort flag to 0.
REQ-027 Reset mid-RUN SHALL drop win_enable immediately; the reader is reset by the same rst_n, so alignment is preserved.

Structure
REQ-028 A shared package SHALL hold the state enum, N_SAMPLES, ADDR_WIDTH and LAT, shared with the window reader.
REQ-029 The sequencer SHALL be a single module with no sub-modules; the bench instantiates it with the window reader.

Verification
REQ-030 Scenario 1: N=2, G=4, LAT=3, start at cycle 0 -> win_enable high 1–128 and 136–263; chirp_done at 131 and 266; frame_done at 266 with aborted=0; busy low at 267.
REQ-031 Scenario 2: start with cfg_num_chirps=0 -> busy stays 0 and win_enable is never asserted.
REQ-032 Scenario 3: N=4, G=0, abort at cycle 50 -> chirp 0 still gets 128 enables; frame_done with aborted=1 at cycle 131; no second chirp.
REQ-033 Scenario 4: N=3, G=10, abort during the first GAP -> frame_done with aborted=1 the next cycle, then IDLE.
REQ-034 Scenario 5: second start during RUN, and cfg_num_chirps changed mid-frame -> the frame is unchanged and the original chirp count completes.
REQ-035 Scenario 6: rst_n low at cycle 60 of RUN -> all outputs 0 asynchronously; a new start after release gives the reader tdata sequence starting at ROM address 0.
